cpu_core: RTL and testbench

//  32-bit accumulator CPU behind a byte-serial pin handler. Issues one memory transaction per state:

---
 rtl/cpu_core_pkg.sv | 37 +++
 rtl/cpu_core_alu.sv | 36 +++
 rtl/cpu_core.sv | 161 ++++++++++++++++
 tb/tb_cpu_core.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// Shared types and constants for the accumulator CPU core.
package cpu_core_pkg;

  // 4-bit opcode field, instruction bits [31:28]
  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpLdi  = 4'h1,
    OpLd   = 4'h2,
    OpSt   = 4'h3,
    OpAdd  = 4'h4,
    OpSub  = 4'h5,
    OpAnd  = 4'h6,
    OpOr   = 4'h7,
    OpXor  = 4'h8,
    OpJmp  = 4'h9,
    OpJz   = 4'hA,
    OpJc   = 4'hB,
    OpAddi = 4'hC,
    OpShl  = 4'hD,
    OpShr  = 4'hE,
    OpHalt = 4'hF
  } opcode_e;

  // Control FSM states
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // One bit per opcode; set for ops that need a data-memory transaction (LD..XOR)
  localparam logic [15:0] OP_MEM_MASK = 16'h01FC;

  function automatic logic is_mem_op(input opcode_e op);
    return OP_MEM_MASK[op];
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU: result and carry/borrow for the accumulator datapath.
module cpu_core_alu
  import cpu_core_pkg::*;
(
  input  opcode_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_carry
);

  logic [32:0] w_sum;
  logic [32:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Bit 32 of the difference is the borrow
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Select the operation result; non-ALU ops pass the accumulator through
  always_comb begin
    o_result = i_a;
    o_carry  = 1'b0;
    case (i_op)
      OpLdi, OpLd:   o_result = i_b;
      OpAdd, OpAddi: {o_carry, o_result} = w_sum;
      OpSub:         {o_carry, o_result} = w_diff;
      OpAnd:         o_result = i_a & i_b;
      OpOr:          o_result = i_a | i_b;
      OpXor:         o_result = i_a ^ i_b;
      OpShl:         o_result = i_a << i_b[4:0];
      OpShr:         o_result = i_a >> i_b[4:0];
      default:       ;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// 32-bit accumulator CPU, one bus transaction per state, advanced by step.
// Optional carry flag and JC instruction enabled by defining CPU_CORE_CARRY_EN.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] addr,
  output logic        rw,
  output logic        halted
);

  logic [31:0] r_pc, r_acc, r_ir, r_addr, r_dout;
  logic [1:0]  r_state;
  logic        r_rw;
  logic [31:0] w_pc_nxt, w_acc_nxt, w_ir_nxt, w_addr_nxt, w_dout_nxt;
  logic [1:0]  w_state_nxt;
  logic        w_rw_nxt;
`ifdef CPU_CORE_CARRY_EN
  logic        r_c, w_c_nxt;
`endif

  opcode_e     w_op;
  logic [31:0] w_imm, w_alu_b, w_alu_result;
  logic        w_alu_carry;

  assign w_op    = opcode_e'(r_ir[31:28]);
  assign w_imm   = {4'h0, r_ir[27:0]};
  assign w_alu_b = (r_state == ST_MEM) ? data_in : w_imm;

  cpu_core_alu u_alu (
    .i_op     (w_op),
    .i_a      (r_acc),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

`ifndef CPU_CORE_CARRY_EN
  logic w_unused_carry;
  assign w_unused_carry = w_alu_carry;
`endif

  // Next-state logic; everything holds unless step is high
  always_comb begin
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_nxt    = r_ir;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_rw_nxt    = r_rw;
    w_state_nxt = r_state;
`ifdef CPU_CORE_CARRY_EN
    w_c_nxt     = r_c;
`endif
    if (step) begin
      case (r_state)
        ST_FETCH: begin
          w_ir_nxt    = data_in;
          w_pc_nxt    = r_pc + 32'd1;
          w_state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          if (is_mem_op(w_op)) begin
            w_state_nxt = ST_MEM;
            w_addr_nxt  = w_imm;
            w_rw_nxt    = (w_op != OpSt);
            w_dout_nxt  = (w_op == OpSt) ? r_acc : 32'h0;
          end else begin
            w_state_nxt = ST_FETCH;
            // PC was already advanced in FETCH; jumps overwrite it here
            w_addr_nxt  = r_pc;
            case (w_op)
              OpLdi, OpShl, OpShr: w_acc_nxt = w_alu_result;
              OpAddi: begin
                w_acc_nxt = w_alu_result;
`ifdef CPU_CORE_CARRY_EN
                w_c_nxt   = w_alu_carry;
`endif
              end
              OpJmp: begin
                w_pc_nxt   = w_imm;
                w_addr_nxt = w_imm;
              end
              OpJz: begin
                if (r_acc == 32'h0) begin
                  w_pc_nxt   = w_imm;
                  w_addr_nxt = w_imm;
                end
              end
`ifdef CPU_CORE_CARRY_EN
              OpJc: begin
                if (r_c) begin
                  w_pc_nxt   = w_imm;
                  w_addr_nxt = w_imm;
                end
              end
`endif
              OpHalt: begin
                w_state_nxt = ST_HALT;
                w_addr_nxt  = r_addr;
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          if (w_op != OpSt) begin
            w_acc_nxt = w_alu_result;
`ifdef CPU_CORE_CARRY_EN
            if (w_op == OpAdd || w_op == OpSub) w_c_nxt = w_alu_carry;
`endif
          end
          w_state_nxt = ST_FETCH;
          w_addr_nxt  = r_pc;
          w_rw_nxt    = 1'b1;
          w_dout_nxt  = 32'h0;
        end
        default: ;  // HALT: only reset leaves
      endcase
    end
  end

  // State and bus-output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_acc   <= 32'h0;
      r_ir    <= 32'h0;
      r_addr  <= RESET_PC;
      r_dout  <= 32'h0;
      r_rw    <= 1'b1;
      r_state <= ST_FETCH;
`ifdef CPU_CORE_CARRY_EN
      r_c     <= 1'b0;
`endif
    end else begin
      r_pc    <= w_pc_nxt;
      r_acc   <= w_acc_nxt;
      r_ir    <= w_ir_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_rw    <= w_rw_nxt;
      r_state <= w_state_nxt;
`ifdef CPU_CORE_CARRY_EN
      r_c     <= w_c_nxt;
`endif
    end
  end

  assign addr     = r_addr;
  assign data_out = r_dout;
  assign rw       = r_rw;
  assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: instruction-level reference model producing the
// expected per-step bus sequence, plus directed programs with literal expectations.
// Honours CPU_CORE_CARRY_EN for the JC/carry test.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out, addr;
  logic        rw, halted;

  cpu_core #(.RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .data_in  (data_in),
    .data_out (data_out),
    .addr     (addr),
    .rw       (rw),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  logic [31:0] mem [256];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] dout;
    logic        halted;
  } bus_t;

  bus_t        exp_q[$];
  bus_t        cur;
  logic [31:0] m_pc, m_acc;
`ifdef CPU_CORE_CARRY_EN
  logic        m_c;
`endif

  function automatic void model_reset();
    m_pc  = 32'h0;
    m_acc = 32'h0;
`ifdef CPU_CORE_CARRY_EN
    m_c   = 1'b0;
`endif
    exp_q.delete();
    cur = '{addr: 32'h0, rw: 1'b1, dout: 32'h0, halted: 1'b0};
  endfunction

  // Execute one whole instruction and queue the bus view of each following step.
  function automatic void interpret(input logic [31:0] ins);
    logic [3:0]  op;
    logic [31:0] imm, mv;
    op   = ins[31:28];
    imm  = {4'h0, ins[27:0]};
    m_pc = m_pc + 32'd1;
    exp_q.push_back('{addr: cur.addr, rw: 1'b1, dout: 32'h0, halted: 1'b0});
    if (op >= 4'h2 && op <= 4'h8) begin
      mv = mem[imm[7:0]];
      exp_q.push_back('{addr: imm, rw: (op != 4'h3), dout: (op == 4'h3) ? m_acc : 32'h0,
                        halted: 1'b0});
      case (op)
        4'h2: m_acc = mv;
        4'h4: begin
`ifdef CPU_CORE_CARRY_EN
          m_c = ({1'b0, m_acc} + {1'b0, mv}) > 33'hFFFF_FFFF;
`endif
          m_acc = m_acc + mv;
        end
        4'h5: begin
`ifdef CPU_CORE_CARRY_EN
          m_c = m_acc < mv;
`endif
          m_acc = m_acc - mv;
        end
        4'h6: m_acc = m_acc & mv;
        4'h7: m_acc = m_acc | mv;
        4'h8: m_acc = m_acc ^ mv;
        default: ;
      endcase
      exp_q.push_back('{addr: m_pc, rw: 1'b1, dout: 32'h0, halted: 1'b0});
    end else if (op == 4'hF) begin
      exp_q.push_back('{addr: cur.addr, rw: 1'b1, dout: 32'h0, halted: 1'b1});
    end else begin
      case (op)
        4'h1: m_acc = imm;
        4'h9: m_pc = imm;
        4'hA: if (m_acc == 32'h0) m_pc = imm;
`ifdef CPU_CORE_CARRY_EN
        4'hB: if (m_c) m_pc = imm;
`endif
        4'hC: begin
`ifdef CPU_CORE_CARRY_EN
          m_c = ({1'b0, m_acc} + {1'b0, imm}) > 33'hFFFF_FFFF;
`endif
          m_acc = m_acc + imm;
        end
        4'hD: m_acc = m_acc << imm[4:0];
        4'hE: m_acc = m_acc >> imm[4:0];
        default: ;
      endcase
      exp_q.push_back('{addr: m_pc, rw: 1'b1, dout: 32'h0, halted: 1'b0});
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (step && !cur.halted) begin
        if (exp_q.size() == 0) interpret(mem[cur.addr[7:0]]);
        cur = exp_q.pop_front();
      end
    end
  end

  // Compare DUT bus outputs with the model every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("addr", addr, cur.addr);
      check("rw", {31'h0, rw}, {31'h0, cur.rw});
      check("data_out", data_out, cur.dout);
      check("halted", {31'h0, halted}, {31'h0, cur.halted});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    step  = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Handler frames: collect write data, present read data, strobe step once
  task automatic do_steps(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (!rw) mem[addr[7:0]] = data_out;
      data_in = rw ? mem[addr[7:0]] : 32'h0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      data_in = 32'hDEAD_BEEF;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    // LDI then ST
    do_reset();
    mem[0] = 32'h1000_0055; mem[1] = 32'h3000_0010; mem[2] = 32'hF000_0000;
    do_steps(4, 0);
    check("st_addr", addr, 32'h10);
    check("st_rw", {31'h0, rw}, 32'h0);
    check("st_dout", data_out, 32'h55);
    do_steps(6, 1);
    check("st_mem", mem[8'h10], 32'h55);
    check("st_halted", {31'h0, halted}, 32'h1);

    // Async reset in the middle of a store frame
    do_reset();
    mem[0] = 32'h1000_0055; mem[1] = 32'h3000_0010; mem[2] = 32'hF000_0000;
    do_steps(4, 0);
    check("pre_rst_rw", {31'h0, rw}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", addr, 32'h0);
    check("rst_rw", {31'h0, rw}, 32'h1);
    check("rst_dout", data_out, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_no_store", mem[8'h10], 32'h0);

    // Step gating in FETCH
    do_reset();
    mem[0] = 32'h1000_0077; mem[1] = 32'h3000_0011; mem[2] = 32'hF000_0000;
    data_in = 32'h1234_5678;
    repeat (20) @(negedge clk);
    check("gate_addr", addr, 32'h0);
    check("gate_rw", {31'h0, rw}, 32'h1);
    do_steps(4, 0);
    check("gate_ir_dout", data_out, 32'h77);
    do_steps(6, 0);

    // ALU wrap: ADD then SUB through memory
    do_reset();
    mem[0] = 32'h1FFF_FFFF; mem[1] = 32'h4000_0040; mem[2] = 32'h3000_0041;
    mem[3] = 32'h5000_0042; mem[4] = 32'h3000_0043; mem[5] = 32'hF000_0000;
    mem[8'h40] = 32'h1; mem[8'h42] = 32'h1000_0001;
    do_steps(24, 1);
    check("add_res", mem[8'h41], 32'h1000_0000);
    check("sub_wrap", mem[8'h43], 32'hFFFF_FFFF);

    // Branch taken then halt, frozen under further steps
    do_reset();
    mem[0] = 32'h1000_0000; mem[1] = 32'hA000_0020; mem[8'h20] = 32'hF000_0000;
    do_steps(4, 0);
    check("jz_addr", addr, 32'h20);
    do_steps(2, 0);
    check("halt_flag", {31'h0, halted}, 32'h1);
    do_steps(10, 0);
    check("halt_addr", addr, 32'h20);
    check("halt_rw", {31'h0, rw}, 32'h1);
    check("halt_hold", {31'h0, halted}, 32'h1);

    // Logic ops, shifts, ADDI, JMP, LD
    do_reset();
    mem[0] = 32'h1000_00F0; mem[1] = 32'h6000_0050; mem[2] = 32'h7000_0051;
    mem[3] = 32'h8000_0052; mem[4] = 32'hD000_0004; mem[5] = 32'hE000_0008;
    mem[6] = 32'hC000_0005; mem[7] = 32'h9000_0009; mem[8] = 32'hF000_0000;
    mem[9] = 32'h3000_0054; mem[10] = 32'h2000_0053; mem[11] = 32'h3000_0055;
    mem[12] = 32'hF000_0000;
    mem[8'h50] = 32'h3C; mem[8'h51] = 32'h101; mem[8'h52] = 32'h1; mem[8'h53] = 32'hABCD;
    do_steps(40, 0);
    check("ops_acc", mem[8'h54], 32'h18);
    check("ld_acc", mem[8'h55], 32'hABCD);

    // Carry / JC (op B is a NOP without the carry feature), JZ not taken
    do_reset();
    mem[0] = 32'h1FFF_FFFF; mem[1] = 32'hD000_0004; mem[2] = 32'hC000_000F;
    mem[3] = 32'hC000_0001; mem[4] = 32'hB000_0030; mem[5] = 32'h1000_0BAD;
    mem[6] = 32'h3000_0060; mem[7] = 32'hF000_0000;
    mem[8'h30] = 32'h1000_0C00; mem[8'h31] = 32'h3000_0060; mem[8'h32] = 32'hA000_0040;
    mem[8'h33] = 32'hF000_0000;
    do_steps(40, 0);
`ifdef CPU_CORE_CARRY_EN
    check("jc_taken", mem[8'h60], 32'hC00);
`else
    check("op_b_nop", mem[8'h60], 32'hBAD);
`endif
    check("carry_halt", {31'h0, halted}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
